// File: rtl/mld_7_4_pkg.sv
// Shared constants, FSM encoding and codeword type for the (7,4) cyclic Hamming encoder/decoder.
package mld_7_4_pkg;

  localparam int unsigned N = 7;
  localparam int unsigned K = 4;
  localparam int unsigned M = 3;

  // Generator coefficients {g3,g2,g1,g0}; 1 + x + x^3.
  localparam logic [3:0] GenPolyDefault = 4'b1011;

  typedef logic [0:6] codeword_t;

  typedef logic [1:0] enc_state_t;
  localparam enc_state_t StIdle = 2'd0;
  localparam enc_state_t StMsg  = 2'd1;
  localparam enc_state_t StPar  = 2'd2;
  localparam enc_state_t StDone = 2'd3;

endpackage

// File: rtl/mld_lfsr_3.sv
// 3-stage parity LFSR for a degree-3 generator; exposes its next state so the caller can
// emit the first parity bit in the same cycle as the last message shift.
module mld_lfsr_3
  import mld_7_4_pkg::*;
#(
  parameter logic [3:0] GEN_POLY = GenPolyDefault
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       shift_i,
  input  logic       fb_en_i,
  input  logic       data_i,
  output logic [0:2] state_next_o
);

  logic [0:2] state_q, state_d;
  logic       fb;

  always_comb begin
    fb      = fb_en_i & (data_i ^ state_q[2]);
    state_d = state_q;
    if (clear_i) begin
      state_d = '0;
    end else if (shift_i) begin
      // With fb_en_i low this degenerates to a plain shift toward r2.
      state_d = {fb, state_q[0] ^ (GEN_POLY[1] & fb), state_q[1] ^ (GEN_POLY[2] & fb)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_next_o = state_d;

endmodule

// File: rtl/mld_7_4_encoder.sv
// Serial systematic (7,4) cyclic Hamming encoder, 8 cycles per codeword.
// Optional MLD_ENC_ERR_INJECT_EN adds err_mask, XORed into the serial and parallel outputs.
module mld_7_4_encoder
  import mld_7_4_pkg::*;
#(
  parameter logic [3:0] GEN_POLY = GenPolyDefault
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [0:3] message_in,
`ifdef MLD_ENC_ERR_INJECT_EN
  input  logic [0:6] err_mask,
`endif
  output logic       busy,
  output logic       serial_out,
  output logic       serial_valid,
  output logic [0:6] codeword_out,
  output logic       done
);

  if (GEN_POLY != 4'b1011 && GEN_POLY != 4'b1101) begin : g_bad_poly
    $error("mld_7_4_encoder: GEN_POLY must be 4'b1011 or 4'b1101");
  end

  logic [0:6] mask_in;
`ifdef MLD_ENC_ERR_INJECT_EN
  assign mask_in = err_mask;
`else
  assign mask_in = '0;
`endif

  enc_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d, cnt_inc;
  logic [0:3] msg_q, msg_d;
  logic [0:6] mask_q, mask_d;
  logic [0:6] mask_sr_q, mask_sr_d;  // serial-order mask; bit 6 applies to the next bit out
  logic [0:2] par_q, par_d;
  logic       busy_q, busy_d;
  logic       ser_q, ser_d;
  logic       ser_vld_q, ser_vld_d;
  codeword_t  cw_q, cw_d;
  logic       done_q, done_d;

  logic       lfsr_clear, lfsr_shift, lfsr_fb_en, lfsr_din;
  logic [0:2] lfsr_next;
  logic       accept;

  assign cnt_inc = cnt_q + 3'd1;
  assign accept  = load && (state_q == StIdle || state_q == StDone);

  // Kept apart from the main next-state block so lfsr_next has no path back into itself.
  always_comb begin
    lfsr_clear = accept;
    lfsr_shift = 1'b0;
    lfsr_fb_en = 1'b0;
    lfsr_din   = 1'b0;
    if (state_q == StMsg) begin
      lfsr_shift = 1'b1;
      lfsr_fb_en = 1'b1;
      lfsr_din   = msg_q[~cnt_q[1:0]];
    end else if (state_q == StPar && cnt_q != 3'd2) begin
      lfsr_shift = 1'b1;
    end
  end

  mld_lfsr_3 #(
    .GEN_POLY (GEN_POLY)
  ) u_lfsr (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (lfsr_clear),
    .shift_i      (lfsr_shift),
    .fb_en_i      (lfsr_fb_en),
    .data_i       (lfsr_din),
    .state_next_o (lfsr_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    msg_d     = msg_q;
    mask_d    = mask_q;
    mask_sr_d = mask_sr_q;
    par_d     = par_q;
    busy_d    = busy_q;
    ser_d     = ser_q;
    ser_vld_d = ser_vld_q;
    cw_d      = cw_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          state_d   = StMsg;
          cnt_d     = 3'd0;
          msg_d     = message_in;
          mask_d    = mask_in;
          mask_sr_d = {1'b0, mask_in[0:5]};
          busy_d    = 1'b1;
          ser_vld_d = 1'b1;
          ser_d     = message_in[3] ^ mask_in[6];
        end
      end
      StMsg: begin
        mask_sr_d = {1'b0, mask_sr_q[0:5]};
        if (cnt_q == 3'd3) begin
          state_d = StPar;
          cnt_d   = 3'd0;
          par_d   = lfsr_next;
          ser_d   = lfsr_next[2] ^ mask_sr_q[6];
        end else begin
          cnt_d = cnt_inc;
          ser_d = msg_q[~cnt_inc[1:0]] ^ mask_sr_q[6];
        end
      end
      StPar: begin
        if (cnt_q == 3'd2) begin
          state_d   = StDone;
          cnt_d     = 3'd0;
          busy_d    = 1'b0;
          ser_vld_d = 1'b0;
          ser_d     = 1'b0;
          done_d    = 1'b1;
          cw_d      = {par_q, msg_q} ^ mask_q;
        end else begin
          cnt_d     = cnt_inc;
          mask_sr_d = {1'b0, mask_sr_q[0:5]};
          ser_d     = lfsr_next[2] ^ mask_sr_q[6];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      msg_q     <= '0;
      mask_q    <= '0;
      mask_sr_q <= '0;
      par_q     <= '0;
      busy_q    <= 1'b0;
      ser_q     <= 1'b0;
      ser_vld_q <= 1'b0;
      cw_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      msg_q     <= msg_d;
      mask_q    <= mask_d;
      mask_sr_q <= mask_sr_d;
      par_q     <= par_d;
      busy_q    <= busy_d;
      ser_q     <= ser_d;
      ser_vld_q <= ser_vld_d;
      cw_q      <= cw_d;
      done_q    <= done_d;
    end
  end

  assign busy         = busy_q;
  assign serial_out   = ser_q;
  assign serial_valid = ser_vld_q;
  assign codeword_out = cw_q;
  assign done         = done_q;

endmodule

// File: tb/tb_mld_7_4_encoder.sv
// Bench for mld_7_4_encoder: polynomial-division model plus directed vectors, two GEN_POLY builds.
module tb_mld_7_4_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [0:3] message_in = '0;
  logic [0:6] err_mask_v = '0;

  logic       busy1, ser1, vld1, done1;
  logic [0:6] cw1;
  logic       busy2, ser2, vld2, done2;
  logic [0:6] cw2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mld_7_4_encoder #(.GEN_POLY(4'b1011)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .message_in   (message_in),
`ifdef MLD_ENC_ERR_INJECT_EN
    .err_mask     (err_mask_v),
`endif
    .busy         (busy1),
    .serial_out   (ser1),
    .serial_valid (vld1),
    .codeword_out (cw1),
    .done         (done1)
  );

  mld_7_4_encoder #(.GEN_POLY(4'b1101)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .message_in   (message_in),
`ifdef MLD_ENC_ERR_INJECT_EN
    .err_mask     (err_mask_v),
`endif
    .busy         (busy2),
    .serial_out   (ser2),
    .serial_valid (vld2),
    .codeword_out (cw2),
    .done         (done2)
  );

  // Codeword {b0,b1,b2,u0..u3} with b = x^3*u(x) mod g(x), by long division on integers.
  function automatic logic [0:6] enc(input logic [0:3] m, input logic [3:0] gp);
    int unsigned u, g, rem;
    logic [0:6] cw;
    u = 0;
    g = 0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) u |= (32'd1 << i);
      if (gp[i]) g |= (32'd1 << i);
    end
    rem = u << 3;
    for (int d = 6; d >= 3; d--) begin
      if (((rem >> d) & 32'd1) != 0) rem ^= (g << (d - 3));
    end
    for (int i = 0; i < 3; i++) cw[i] = ((rem >> i) & 32'd1) != 0;
    for (int i = 0; i < 4; i++) cw[3 + i] = m[i];
    return cw;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: ph counts cycles since the accepting edge (1..7 streaming, 8 = done cycle).
  int         ph = 0;
  logic [0:6] cur1 = '0, cur2 = '0, out1 = '0, out2 = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph   = 0;
      out1 = '0;
      out2 = '0;
    end else if ((ph == 0 || ph == 8) && load) begin
      ph   = 1;
      cur1 = enc(message_in, 4'b1011) ^ err_mask_v;
      cur2 = enc(message_in, 4'b1101) ^ err_mask_v;
    end else if (ph == 8) begin
      ph = 0;
    end else if (ph == 7) begin
      ph   = 8;
      out1 = cur1;
      out2 = cur2;
    end else if (ph >= 1) begin
      ph = ph + 1;
    end
  end

  always @(negedge clk) begin
    logic       eb, es1, es2;
    logic [2:0] idx;
    eb  = (ph >= 1 && ph <= 7);
    idx = 3'(7 - ph);
    es1 = eb ? cur1[idx] : 1'b0;
    es2 = eb ? cur2[idx] : 1'b0;
    chk("cycle dut1 {busy,valid,serial,done,cw}", {21'd0, busy1, vld1, ser1, done1, cw1},
        {21'd0, eb, eb, es1, (ph == 8), out1});
    chk("cycle dut2 {busy,valid,serial,done,cw}", {21'd0, busy2, vld2, ser2, done2, cw2},
        {21'd0, eb, eb, es2, (ph == 8), out2});
  end

  task automatic run_cw(input string name, input logic [0:3] m, input logic [0:6] mk,
                        input logic [0:6] exp_stream, input logic [0:6] exp_cw);
    logic [0:6] got;
    @(negedge clk);
    load       = 1'b1;
    message_in = m;
    err_mask_v = mk;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      load       = 1'b0;
      message_in = '0;
      got[k]     = ser1;
    end
    @(negedge clk);
    chk({name, " stream"}, {25'd0, got}, {25'd0, exp_stream});
    chk({name, " done"}, {31'd0, done1}, 32'd1);
    chk({name, " codeword"}, {25'd0, cw1}, {25'd0, exp_cw});
    err_mask_v = '0;
  endtask

  initial begin
    int dcnt;
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int dcnt;
    chk("model 1011", {25'd0, enc(4'b1011, 4'b1011)}, 32'b1001011);
    chk("model 1110", {25'd0, enc(4'b1110, 4'b1011)}, 32'b0101110);
    chk("model 1000 poly 1101", {25'd0, enc(4'b1000, 4'b1101)}, 32'b1011000);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset outputs", {21'd0, busy1, vld1, ser1, done1, cw1}, 32'd0);

    run_cw("msg 1011", 4'b1011, 7'b0, 7'b1101001, 7'b1001011);
    run_cw("msg 1000", 4'b1000, 7'b0, 7'b0001011, 7'b1101000);
    chk("poly 1101 msg 1000", {25'd0, cw2}, 32'b1011000);
    run_cw("msg 0000", 4'b0000, 7'b0, 7'b0000000, 7'b0000000);
    run_cw("msg 1111", 4'b1111, 7'b0, 7'b1111111, 7'b1111111);

    // load held high: accepted every 8 cycles, mid-codeword strobes ignored.
    repeat (2) @(negedge clk);
    dcnt = 0;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      if (done1) dcnt++;
      load       = (i < 19);
      message_in = (i < 19) ? 4'b1110 : 4'b0000;
    end
    chk("held load done count", dcnt, 32'd3);
    chk("held load codeword", {25'd0, cw1}, 32'b0101110);

    // Reset while the 4th serial bit is on the line.
    @(negedge clk);
    load       = 1'b1;
    message_in = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      load = 1'b0;
    end
    chk("pre-abort valid", {31'd0, vld1}, 32'd1);
    #2 reset = 1'b1;
    #1 chk("abort outputs", {21'd0, busy1, vld1, ser1, done1, cw1}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dcnt  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done1) dcnt++;
    end
    chk("abort no done", dcnt, 32'd0);
    run_cw("post-abort 1011", 4'b1011, 7'b0, 7'b1101001, 7'b1001011);

`ifdef MLD_ENC_ERR_INJECT_EN
    run_cw("inject 1011", 4'b1011, 7'b0000100, 7'b1111001, 7'b1001111);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
